hex_seq: RTL

HEX_SEQ -- requirements
Module: hex_seq

---
 rtl/hex_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hex_seq.sv
// rtl/hex_seq.sv - request arbiter and 4-digit scan sequencer for a 7-segment register block
//
// Two requesters (A, B) post 16-bit values. Round-robin arbitration picks one,
// latches its value and scans the four nibbles out to the decoder, one digit
// per cycle.
//
// Optional feature: define HEX_SEQ_REFRESH_EN to re-scan the latched value
// after REFRESH consecutive idle cycles. It is off by default.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_a/req_b  level requests, held until the matching ack
//   val_a/val_b  16-bit values, sampled in the ack cycle
//   ack_a/ack_b  one-cycle grant pulses
//   en           decoder write strobe (high only while scanning)
//   val          nibble to the decoder
//   dig          digit index 0..3
//   busy         high whenever the sequencer is not idle
//   owner        source of the latched value, 0=A, 1=B
module hex_seq #(
  parameter logic [15:0] REFRESH = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] val_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] val_b,
  output logic        ack_b,
  output logic        en,
  output logic [3:0]  val,
  output logic [1:0]  dig,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] data;
  logic [1:0]  k;       // digit currently being written during SCAN
  logic        prio_b;  // 1: B wins the next tie (A won the last grant)
  logic        win_a;
  logic        win_b;

  // The winner is decided from the request levels seen in the GRANT cycle
  // itself. A request that has already dropped there gets no ack.
  always_comb begin
    win_a = req_a & (~req_b | ~prio_b);
    win_b = req_b & (~req_a |  prio_b);
  end

`ifdef HEX_SEQ_REFRESH_EN
  logic [15:0] idle_cnt;
  logic        refresh_hit;

  always_comb begin
    refresh_hit = (idle_cnt == (REFRESH - 16'd1));
  end
`else
  logic unused_refresh;

  assign unused_refresh = ^REFRESH;
`endif

  always_comb begin
    state_nxt = state;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    en        = 1'b0;
    dig       = 2'd0;
    val       = 4'd0;
    case (state)
      IDLE: begin
        // A pending request beats an expiring refresh on the same edge.
        if (req_a || req_b) begin
          state_nxt = GRANT;
        end
`ifdef HEX_SEQ_REFRESH_EN
        else if (refresh_hit) begin
          state_nxt = SCAN;
        end
`endif
      end
      GRANT: begin
        ack_a = win_a;
        ack_b = win_b;
        // Both requests withdrawn before the grant: nothing was latched.
        // Return to IDLE instead of rescanning stale data.
        state_nxt = (win_a || win_b) ? SCAN : IDLE;
      end
      SCAN: begin
        en  = 1'b1;
        dig = k;
        val = data[{k, 2'b00} +: 4];
        if (k == 2'd3) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data   <= 16'h0000;
      owner  <= 1'b0;
      prio_b <= 1'b0;
      k      <= 2'd0;
    end else begin
      state <= state_nxt;
      // The digit index only advances while scanning. It naturally wraps
      // back to 0 on the last digit.
      if (state == SCAN) begin
        k <= k + 2'd1;
      end else begin
        k <= 2'd0;
      end
      if (ack_a) begin
        data   <= val_a;
        owner  <= 1'b0;
        prio_b <= 1'b1;
      end else if (ack_b) begin
        data   <= val_b;
        owner  <= 1'b1;
        prio_b <= 1'b0;
      end
    end
  end

`ifdef HEX_SEQ_REFRESH_EN
  // Counts consecutive IDLE cycles that stay in IDLE. Leaving IDLE, either
  // to GRANT or to a refresh SCAN, clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 16'd0;
    end else if ((state == IDLE) && (state_nxt == IDLE)) begin
      idle_cnt <= idle_cnt + 16'd1;
    end else begin
      idle_cnt <= 16'd0;
    end
  end
`endif

  ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(ack_a && ack_b));
  ack_a_single:  assert property (@(posedge clk) disable iff (rst) ack_a |=> !ack_a);
  ack_b_single:  assert property (@(posedge clk) disable iff (rst) ack_b |=> !ack_b);
  en_busy:       assert property (@(posedge clk) disable iff (rst) en |-> busy);

endmodule
